// File: rtl/field_pkg.sv
// Shared types for the velocity-field normalizer.
//
// Contents:
//   fx_t          signed Q16.16 scalar
//   FX_FRAC       fractional bits of fx_t
//   field_word_t  output word {xn, yn, mag} (96 bits)
//   vel_word_t    input word {vx, vy} (64 bits)
//   state_t       normalizer FSM states
package field_pkg;

    localparam int FX_FRAC     = 16;
    localparam int FIELD_DATAW = 96;
    localparam int VEL_DATAW   = 64;

    typedef logic signed [31:0] fx_t;

    typedef struct packed {
        fx_t xn;
        fx_t yn;
        fx_t mag;
    } field_word_t;

    typedef struct packed {
        fx_t vx;
        fx_t vy;
    } vel_word_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        SQUARE = 3'd2,
        SQRT   = 3'd3,
        DIVIDE = 3'd4,
        WRITE  = 3'd5
    } state_t;

endpackage

// File: rtl/fx_div_u32.sv
// Unsigned restoring divider: 48-bit dividend / 32-bit divisor -> 32-bit quotient.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      one-cycle pulse; operands are sampled in that cycle
//   dividend   48-bit unsigned dividend
//   divisor    32-bit unsigned divisor (non-zero)
//   valid      one-cycle pulse exactly 33 cycles after start
//   quotient   32-bit floor quotient, held until the next start
//
// Only 32 quotient bits are produced: the upper 16 dividend bits preload the
// remainder, so the caller must guarantee dividend[47:32] < divisor.
module fx_div_u32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [47:0] dividend,
    input  logic [31:0] divisor,
    output logic        valid,
    output logic [31:0] quotient
);

    logic [31:0] rem;
    logic [31:0] dsr;
    logic [31:0] shreg;     // low dividend bits shift out, quotient bits shift in
    logic [4:0]  cnt;
    logic        run;

    logic [32:0] trial_rem;
    logic        ge;

    always_comb begin
        trial_rem = {rem, shreg[31]};
        ge        = (trial_rem >= {1'b0, dsr});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem   <= '0;
            dsr   <= '0;
            shreg <= '0;
            cnt   <= '0;
            run   <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (start) begin
                rem   <= {16'h0000, dividend[47:32]};
                shreg <= dividend[31:0];
                dsr   <= divisor;
                cnt   <= '0;
                run   <= 1'b1;
            end else if (run) begin
                rem   <= ge ? 32'(trial_rem - {1'b0, dsr}) : trial_rem[31:0];
                shreg <= {shreg[30:0], ge};
                cnt   <= cnt + 5'd1;
                if (cnt == 5'd31) begin
                    run   <= 1'b0;
                    valid <= 1'b1;
                end
            end
        end
    end

    assign quotient = shreg;

endmodule

// File: rtl/field_vec_normalize.sv
// Velocity field normalizer: sweeps the velocity BRAM, writes {xn, yn, mag}
// per cell into the renderer's field BRAM, then pulses done.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin a sweep (only honoured in IDLE)
//   busy              high in every non-IDLE state
//   done              one-cycle pulse after the final cell write
//   vel_addr_read     velocity BRAM read address
//   vel_data_out      velocity BRAM read data {vx, vy}, Q16.16
//   field_addr_write  field BRAM write address
//   field_data_in     field BRAM write data {xn, yn, mag}
//   field_we          field BRAM write enable
//
// Build option FIELD_MAG_CLAMP_EN: when defined, the written magnitude is
// limited to MAG_MAX; direction is always derived from the unclamped value.
module field_vec_normalize
    import field_pkg::*;
#(
    parameter int FIELD_WIDTH  = 8,
    parameter int FIELD_HEIGHT = 6,
    parameter int FIELD_SIZE   = FIELD_WIDTH * FIELD_HEIGHT,
    parameter int FIELD_ADDRW  = $clog2(FIELD_SIZE),
    parameter int VEL_RD_LAT   = 2
`ifdef FIELD_MAG_CLAMP_EN
    ,
    parameter logic [31:0] MAG_MAX = 32'h0010_0000
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [FIELD_ADDRW-1:0] vel_addr_read,
    input  logic [VEL_DATAW-1:0]   vel_data_out,
    output logic [FIELD_ADDRW-1:0] field_addr_write,
    output logic [FIELD_DATAW-1:0] field_data_in,
    output logic                   field_we
);

    localparam logic [FIELD_ADDRW-1:0] LAST_IDX   = FIELD_ADDRW'(FIELD_SIZE - 1);
    localparam logic [7:0]             FETCH_LAST = 8'(VEL_RD_LAT - 1);

    state_t                 state, state_next;
    logic [FIELD_ADDRW-1:0] idx;
    logic [7:0]             fetch_cnt;
    vel_word_t              vel_r;
    logic [31:0]            abs_x, abs_y;
    logic [31:0]            mag_r;

    // Square-root datapath
    logic [63:0] sq_rad;
    logic [32:0] sq_rem;
    logic [31:0] sq_root;
    logic [4:0]  sq_cnt;

    logic [31:0] abs_x_c, abs_y_c;
    logic [63:0] sum_c;
    logic [34:0] rem_shift, trial;
    logic        sq_ge;
    logic [32:0] rem_next;
    logic [31:0] root_next;

    // Divider interface
    logic        div_start;
    logic        valid_x, valid_y, div_valid;
    logic [31:0] q_x, q_y;
    field_word_t div_word;

    function automatic logic [31:0] out_mag(input logic [31:0] m);
`ifdef FIELD_MAG_CLAMP_EN
        return (m > MAG_MAX) ? MAG_MAX : m;
`else
        return m;
`endif
    endfunction

    // Absolute values: two's-complement negate as unsigned, so -2^31 maps to 2^31.
    always_comb begin
        abs_x_c = vel_r.vx[31] ? (~vel_r.vx + 32'd1) : vel_r.vx;
        abs_y_c = vel_r.vy[31] ? (~vel_r.vy + 32'd1) : vel_r.vy;
        sum_c   = ({32'h0, abs_x_c} * {32'h0, abs_x_c}) + ({32'h0, abs_y_c} * {32'h0, abs_y_c});
    end

    // One restoring sqrt step: bring down two radicand bits, try (4*root + 1).
    always_comb begin
        rem_shift = {sq_rem, sq_rad[63:62]};
        trial     = {1'b0, sq_root, 2'b01};
        sq_ge     = (rem_shift >= trial);
        rem_next  = sq_ge ? 33'(rem_shift - trial) : 33'(rem_shift);
        root_next = {sq_root[30:0], sq_ge};
    end

    // Signs reapplied after the unsigned divide give truncation toward zero.
    always_comb begin
        div_valid    = valid_x & valid_y;
        div_word.xn  = vel_r.vx[31] ? (~q_x + 32'd1) : q_x;
        div_word.yn  = vel_r.vy[31] ? (~q_y + 32'd1) : q_y;
        div_word.mag = out_mag(mag_r);
    end

    always_comb begin
        state_next = state;
        div_start  = 1'b0;
        case (state)
            IDLE:   if (start) state_next = FETCH;
            FETCH:  if (fetch_cnt == FETCH_LAST) state_next = SQUARE;
            SQUARE: state_next = SQRT;
            SQRT: begin
                if (sq_cnt == 5'd31) begin
                    // The final root is known combinationally here, so the
                    // dividers start now and deliver in the last DIVIDE cycle.
                    if (root_next == 32'd0) begin
                        state_next = WRITE;
                    end else begin
                        state_next = DIVIDE;
                        div_start  = 1'b1;
                    end
                end
            end
            DIVIDE: if (div_valid) state_next = WRITE;
            WRITE:  state_next = (idx == LAST_IDX) ? IDLE : FETCH;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx              <= '0;
            vel_addr_read    <= '0;
            field_addr_write <= '0;
            field_data_in    <= '0;
            done             <= 1'b0;
            fetch_cnt        <= '0;
            vel_r            <= '0;
            abs_x            <= '0;
            abs_y            <= '0;
            mag_r            <= '0;
            sq_rad           <= '0;
            sq_rem           <= '0;
            sq_root          <= '0;
            sq_cnt           <= '0;
        end else begin
            done <= (state == WRITE) && (idx == LAST_IDX);
            case (state)
                IDLE: begin
                    if (start) begin
                        idx           <= '0;
                        vel_addr_read <= '0;
                        fetch_cnt     <= '0;
                    end
                end
                FETCH: begin
                    fetch_cnt <= fetch_cnt + 8'd1;
                    if (fetch_cnt == FETCH_LAST) vel_r <= vel_word_t'(vel_data_out);
                end
                SQUARE: begin
                    abs_x   <= abs_x_c;
                    abs_y   <= abs_y_c;
                    sq_rad  <= sum_c;
                    sq_rem  <= '0;
                    sq_root <= '0;
                    sq_cnt  <= '0;
                end
                SQRT: begin
                    sq_rem  <= rem_next;
                    sq_root <= root_next;
                    sq_rad  <= {sq_rad[61:0], 2'b00};
                    sq_cnt  <= sq_cnt + 5'd1;
                    if (sq_cnt == 5'd31) begin
                        mag_r <= root_next;
                        if (root_next == 32'd0) begin
                            field_data_in    <= '0;
                            field_addr_write <= idx;
                        end
                    end
                end
                DIVIDE: begin
                    if (div_valid) begin
                        field_data_in    <= div_word;
                        field_addr_write <= idx;
                    end
                end
                WRITE: begin
                    if (idx != LAST_IDX) begin
                        idx           <= idx + 1'b1;
                        vel_addr_read <= idx + 1'b1;
                        fetch_cnt     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign field_we = (state == WRITE);

    // Dividends are |v| scaled by 2^16; |v| <= mag keeps the quotient within 32 bits.
    fx_div_u32 u_div_x (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend ({abs_x, {FX_FRAC{1'b0}}}),
        .divisor  (root_next),
        .valid    (valid_x),
        .quotient (q_x)
    );

    fx_div_u32 u_div_y (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend ({abs_y, {FX_FRAC{1'b0}}}),
        .divisor  (root_next),
        .valid    (valid_y),
        .quotient (q_y)
    );

endmodule

// File: tb/tb_field_vec_normalize.sv
// Bench for field_vec_normalize: velocity BRAM model, write/done monitor,
// reference model of the normalization, and per-scenario test tasks.
module tb_field_vec_normalize;

    localparam int NCELL     = 48;
    localparam int LAT_FULL  = 2 + 67;
    localparam int LAT_ZERO  = 2 + 34;
    localparam logic [31:0] TB_MAG_MAX = 32'h0002_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [5:0]  vel_addr_read;
    logic [63:0] vel_data_out;
    logic [5:0]  field_addr_write;
    logic [95:0] field_data_in;
    logic        field_we;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [63:0] vel_mem [NCELL];
    logic [95:0] exp_q [$];
    logic [5:0]  wr_addr_q [$];
    logic [95:0] wr_data_q [$];
    int          wr_cyc_q [$];
    int          done_cnt  = 0;
    int          done_cyc  = 0;
    logic        done_busy = 1'b0;

    field_vec_normalize #(
        .FIELD_WIDTH (8),
        .FIELD_HEIGHT(6),
        .VEL_RD_LAT  (2)
`ifdef FIELD_MAG_CLAMP_EN
        ,
        .MAG_MAX     (TB_MAG_MAX)
`endif
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .vel_addr_read   (vel_addr_read),
        .vel_data_out    (vel_data_out),
        .field_addr_write(field_addr_write),
        .field_data_in   (field_data_in),
        .field_we        (field_we)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Velocity BRAM: read data follows the address one clock later and is
    // therefore stable by the final fetch cycle.
    always @(posedge clk) vel_data_out <= vel_mem[vel_addr_read];

    always @(negedge clk) begin
        if (field_we) begin
            wr_addr_q.push_back(field_addr_write);
            wr_data_q.push_back(field_data_in);
            wr_cyc_q.push_back(cyc);
        end
        if (done) begin
            done_cnt  = done_cnt + 1;
            done_cyc  = cyc;
            done_busy = busy;
        end
    end

    // reference model
    function automatic logic [31:0] tb_mag(input logic [31:0] m);
`ifdef FIELD_MAG_CLAMP_EN
        return (m > TB_MAG_MAX) ? TB_MAG_MAX : m;
`else
        return m;
`endif
    endfunction

    function automatic logic [95:0] ref_word(input logic [63:0] v);
        logic [31:0] vx, vy, xn, yn;
        longint unsigned ax, ay, sum, lo, hi, mid, qx, qy;
        vx = v[63:32];
        vy = v[31:0];
        ax = vx[31] ? (64'h1_0000_0000 - {32'h0, vx}) : {32'h0, vx};
        ay = vy[31] ? (64'h1_0000_0000 - {32'h0, vy}) : {32'h0, vy};
        sum = ax * ax + ay * ay;
        lo = 0;
        hi = 64'h1_0000_0000;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= sum) lo = mid;
            else hi = mid;
        end
        if (lo == 0) return 96'h0;
        qx = (ax << 16) / lo;
        qy = (ay << 16) / lo;
        xn = qx[31:0];
        yn = qy[31:0];
        if (vx[31]) xn = -xn;
        if (vy[31]) yn = -yn;
        return {xn, yn, tb_mag(lo[31:0])};
    endfunction

    function automatic logic [63:0] rand_vel();
        logic [31:0] a, b;
        case ($urandom_range(0, 4))
            0: begin a = $urandom; b = $urandom; end
            1: begin a = $urandom_range(0, 32'h0010_0000) - 32'h0008_0000;
                     b = $urandom_range(0, 32'h0010_0000) - 32'h0008_0000; end
            2: begin a = 32'h0; b = 32'h0; end
            3: begin a = 32'h0; b = $urandom; end
            default: begin a = $urandom_range(0, 255) - 128; b = $urandom_range(0, 255) - 128; end
        endcase
        return {a, b};
    endfunction

    // driver tasks
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_sweep(input int poke_at, output int s_cyc, output bit to);
        int base;
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        base = done_cnt;
        tick();
        start = 1'b1;
        s_cyc = cyc;
        tick();
        start = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (done_cnt != base) begin
                to = 1'b0;
                break;
            end
            start = (i == poke_at);
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        repeat (3) tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (field_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", field_we); end
        total++; if (vel_addr_read !== 6'd0) begin bad++; $display("FAIL reset_rd_addr: got %h want 0", vel_addr_read); end
        total++; if (field_addr_write !== 6'd0) begin bad++; $display("FAIL reset_wr_addr: got %h want 0", field_addr_write); end
        total++; if (field_data_in !== 96'h0) begin bad++; $display("FAIL reset_data: got %h want 0", field_data_in); end
        start = 1'b0;
        rst = 1'b0;
        repeat (2) tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_hold: got %b want 0", busy); end
    endtask

    task automatic test_basic_vectors();
        int s_cyc;
        bit to;
        for (int i = 0; i < NCELL; i++) vel_mem[i] = rand_vel();
        vel_mem[0] = {32'h0003_0000, 32'h0004_0000};
        vel_mem[1] = {32'hFFFD_0000, 32'h0004_0000};
        vel_mem[2] = 64'h0;
        vel_mem[3] = {32'h8000_0000, 32'h0000_0000};
        run_sweep(-1, s_cyc, to);
        total++; if (to) begin bad++; $display("FAIL basic_timeout: done not seen within 4000 cycles"); end
        total++;
        if (wr_data_q.size() < 4) begin
            bad++;
            $display("FAIL basic_count: got %0d writes want at least 4", wr_data_q.size());
        end else begin
            total++; if (wr_data_q[0] !== {32'h0000_9999, 32'h0000_CCCC, tb_mag(32'h0005_0000)}) begin
                bad++; $display("FAIL basic_word: got %h want %h", wr_data_q[0], {32'h0000_9999, 32'h0000_CCCC, tb_mag(32'h0005_0000)}); end
            total++; if (wr_cyc_q[0] - s_cyc != LAT_FULL) begin
                bad++; $display("FAIL basic_latency: got %0d want %0d", wr_cyc_q[0] - s_cyc, LAT_FULL); end
            total++; if (wr_data_q[1] !== {32'hFFFF_6667, 32'h0000_CCCC, tb_mag(32'h0005_0000)}) begin
                bad++; $display("FAIL sign_word: got %h want %h", wr_data_q[1], {32'hFFFF_6667, 32'h0000_CCCC, tb_mag(32'h0005_0000)}); end
            total++; if (wr_data_q[2] !== 96'h0) begin
                bad++; $display("FAIL zero_word: got %h want 0", wr_data_q[2]); end
            total++; if (wr_cyc_q[2] - wr_cyc_q[1] != LAT_ZERO) begin
                bad++; $display("FAIL zero_latency: got %0d want %0d", wr_cyc_q[2] - wr_cyc_q[1], LAT_ZERO); end
            total++; if (wr_data_q[3] !== {32'hFFFF_0000, 32'h0000_0000, tb_mag(32'h8000_0000)}) begin
                bad++; $display("FAIL extreme_word: got %h want %h", wr_data_q[3], {32'hFFFF_0000, 32'h0000_0000, tb_mag(32'h8000_0000)}); end
            total++; if (wr_cyc_q[3] - wr_cyc_q[2] != LAT_FULL) begin
                bad++; $display("FAIL extreme_latency: got %0d want %0d", wr_cyc_q[3] - wr_cyc_q[2], LAT_FULL); end
        end
        repeat (5) tick();
    endtask

    // Checks one complete sweep against the reference model held in exp_q.
    task automatic check_sweep(input string tag, input int s_cyc, input bit to, input int done_base);
        int prev, want;
        total++; if (to) begin bad++; $display("FAIL %s_timeout: done not seen within 4000 cycles", tag); end
        total++; if (wr_data_q.size() != NCELL) begin
            bad++; $display("FAIL %s_count: got %0d writes want %0d", tag, wr_data_q.size(), NCELL); end
        prev = s_cyc;
        for (int i = 0; i < NCELL && i < wr_data_q.size(); i++) begin
            want = (exp_q[i][31:0] == 32'h0) ? LAT_ZERO : LAT_FULL;
            total++; if (wr_addr_q[i] !== 6'(i)) begin
                bad++; $display("FAIL %s_addr[%0d]: got %0d want %0d", tag, i, wr_addr_q[i], i); end
            total++; if (wr_data_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL %s_data[%0d]: got %h want %h", tag, i, wr_data_q[i], exp_q[i]); end
            total++; if (wr_cyc_q[i] - prev != want) begin
                bad++; $display("FAIL %s_interval[%0d]: got %0d want %0d", tag, i, wr_cyc_q[i] - prev, want); end
            prev = wr_cyc_q[i];
        end
        repeat (5) tick();
        total++; if (done_cnt - done_base != 1) begin
            bad++; $display("FAIL %s_done_pulses: got %0d want 1", tag, done_cnt - done_base); end
        total++; if (done_busy !== 1'b0) begin
            bad++; $display("FAIL %s_done_busy: got %b want 0", tag, done_busy); end
        total++; if (done_cyc != prev + 1) begin
            bad++; $display("FAIL %s_done_cycle: got %0d want %0d", tag, done_cyc, prev + 1); end
    endtask

    task automatic test_full_sweep();
        int s_cyc, base;
        bit to;
        exp_q.delete();
        for (int i = 0; i < NCELL; i++) begin
            vel_mem[i] = rand_vel();
            exp_q.push_back(ref_word(vel_mem[i]));
        end
        base = done_cnt;
        run_sweep(1000, s_cyc, to);
        check_sweep("sweep", s_cyc, to, base);
    endtask

    task automatic test_reset_mid();
        int s_cyc, base, w4, n_before;
        bit to;
        exp_q.delete();
        for (int i = 0; i < NCELL; i++) begin
            vel_mem[i] = rand_vel();
            if (i == 5) vel_mem[i] = {32'h0001_0000, 32'h0002_0000};
            exp_q.push_back(ref_word(vel_mem[i]));
        end
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        base = done_cnt;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 1000 && wr_cyc_q.size() < 5; i++) tick();
        total++;
        if (wr_cyc_q.size() < 5) begin
            bad++;
            $display("FAIL rstmid_reach: got %0d writes want 5", wr_cyc_q.size());
        end else begin
            // cell 5 is in SQRT between 4 and 35 cycles after cell 4's write
            w4 = wr_cyc_q[4];
            for (int i = 0; i < 200 && cyc < w4 + 10; i++) tick();
            rst = 1'b1;
            tick();
            total++; if (field_we !== 1'b0) begin bad++; $display("FAIL rstmid_we: got %b want 0", field_we); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
            total++; if (vel_addr_read !== 6'd0) begin bad++; $display("FAIL rstmid_rd_addr: got %0d want 0", vel_addr_read); end
            rst = 1'b0;
            n_before = wr_cyc_q.size();
            repeat (200) tick();
            total++; if (wr_cyc_q.size() != n_before) begin
                bad++; $display("FAIL rstmid_no_write: got %0d writes want %0d", wr_cyc_q.size(), n_before); end
            total++; if (done_cnt != base) begin
                bad++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_cnt - base); end
        end
        base = done_cnt;
        run_sweep(-1, s_cyc, to);
        check_sweep("resweep", s_cyc, to, base);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        for (int i = 0; i < NCELL; i++) vel_mem[i] = 64'h0;
        test_reset();
        test_basic_vectors();
        test_full_sweep();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/field_vec_normalize.md
Name: field_vec_normalize

Overview:
- Upstream stage of the block renderer.
- On `start`, sweeps every cell of the velocity field BRAM in address order.
- For each velocity (vx, vy) in Q16.16 it computes mag = sqrt(vx²+vy²) and the unit direction xn = vx/mag, yn = vy/mag.
- Writes {xn, yn, mag} into the renderer's field BRAM write port, then pulses `done` so the renderer can be started.

Parameters:
- FIELD_WIDTH, 8, field columns.
- FIELD_HEIGHT, 6, field rows.
- FIELD_SIZE, FIELD_WIDTH*FIELD_HEIGHT, cell count.
- FIELD_ADDRW, $clog2(FIELD_SIZE), field address width.
- FIELD_DATAW, 96, output word width: xn[95:64], yn[63:32], mag[31:0].
- VEL_DATAW, 64, velocity word width: vx[63:32], vy[31:0], signed Q16.16.
- VEL_RD_LAT, 2, cycles from `vel_addr_read` change to valid `vel_data_out`.
- MAG_MAX, 32'h0010_0000, clamp ceiling (used only with FIELD_MAG_CLAMP_EN).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- start  input  1  begin sweep; ignored unless IDLE
- busy  output  1  high in every non-IDLE state
- done  output  1  one-cycle pulse after final cell write
- vel_addr_read  output  FIELD_ADDRW  velocity BRAM read address
- vel_data_out  input  VEL_DATAW  velocity BRAM read data
- field_addr_write  output  FIELD_ADDRW  field BRAM write address
- field_data_in  output  FIELD_DATAW  {xn, yn, mag}
- field_we  output  1  field BRAM write enable

Behaviour:
- Reset (sync, active-high, highest priority):
  - state=IDLE.
  - busy, done, field_we = 0.
  - vel_addr_read, field_addr_write, field_data_in = 0.
- Reset mid-sweep aborts immediately. No further write is issued, and `done` is not pulsed.
- States: IDLE, FETCH, SQUARE, SQRT, DIVIDE, WRITE.
- IDLE: on `start`, cell index=0, vel_addr_read=0, go to FETCH.
- FETCH: held VEL_RD_LAT cycles. On the last cycle, vel_data_out is captured as vx and vy.
- SQUARE (1 cycle):
  - Compute absolute values as 32-bit unsigned. |−2^31| = 2^31 is exact.
  - sum = |vx|²+|vy]² as 64-bit unsigned Q32.32. Maximum is 2^63, so there is no overflow.
- SQRT (32 cycles):
  - Bit-serial restoring integer sqrt of the 64-bit sum.
  - The 32-bit floor result is directly mag in Q16.16.
  - If mag==0, xn=yn=0, skip DIVIDE and go to WRITE.
- DIVIDE (33 cycles):
  - Two fx_div_u32 instances run in parallel: (|vx|<<16)/mag and (|vy|<<16)/mag.
  - Quotients are unsigned floor. Each is negated if its input was negative, giving truncation toward zero.
  - |xn|,|yn| ≤ 0x0001_0000, so no saturation is needed.
- WRITE (1 cycle):
  - field_we=1, field_addr_write=cell index, field_data_in={xn,yn,mag}.
  - If index==FIELD_SIZE-1, go to IDLE and pulse done on the next cycle (busy=0 that cycle).
  - Otherwise index+1, vel_addr_read=index+1, go to FETCH.
- Per-cell latency:
  - mag≠0: VEL_RD_LAT+67 cycles.
  - mag==0: VEL_RD_LAT+34 cycles.
- field_we is high exactly FIELD_SIZE cycles per sweep, with addresses strictly ascending 0..FIELD_SIZE-1 and no wrap.
- start while busy: ignored; no restart or queuing.
- start in the same cycle as rst: reset wins.
- field_data_in holds its last value when field_we=0.

Optional Feature:
- Macro: FIELD_MAG_CLAMP_EN.
- Defined: after SQRT, the written mag = min(mag, MAG_MAX). xn/yn are still computed from the unclamped mag, so direction is unaffected.
- Undefined: mag is written unclamped, and the MAG_MAX parameter is unused.

Decomposition:
- Package field_pkg:
  - fx_t (logic signed [31:0]), FX_FRAC=16.
  - field_word_t packed struct {xn, yn, mag}.
  - vel_word_t packed struct {vx, vy}.
  - State enum.
- Sub-module fx_div_u32: 32-iteration restoring divider.
  - 48-bit dividend, 32-bit divisor.
  - start pulse in, valid pulse out exactly 33 cycles later, 32-bit quotient.
- The sqrt stays inline, since there is a single use.

Test Plan:
- Basic vector: cell0 vx=0x0003_0000, vy=0x0004_0000 → mag=0x0005_0000, xn=0x0000_9999, yn=0x0000_CCCC; write at cycle VEL_RD_LAT+67 after FETCH entry.
- Signs and truncation: vx=0xFFFD_0000 (−3.0), vy=0x0004_0000 → xn=0xFFFF_6667, yn=0x0000_CCCC, mag=0x0005_0000.
- Zero and extreme inputs:
  - vx=vy=0 → word 96'h0 written after VEL_RD_LAT+34 cycles; no divider start.
  - vx=0x8000_0000, vy=0 → mag=0x8000_0000, xn=0xFFFF_0000.
- Full sweep: 48 cells with random velocities vs a reference model → 48 writes at addresses 0..47 in order, one done pulse. A start pulsed mid-sweep changes nothing.
- Reset mid-operation: assert rst during SQRT of cell 5 → field_we=0 and busy=0 next cycle, no done. A new start re-sweeps from address 0.
- Clamp (FIELD_MAG_CLAMP_EN, MAG_MAX=0x0002_0000): (3.0, 4.0) → mag=0x0002_0000, xn=0x0000_9999, yn=0x0000_CCCC.
